hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Producer-side companion to the EX-stage forwarding logic.
- Tracks destination registers whose results are not yet forwardable: loads in flight and multi-cycle long-latency ops such as MUL.
- Stalls the ID-stage instruction until every operand it needs can be forwarded.
- Sits between the decode stage and the IF/ID and ID/EX pipeline registers, driving stall and bubble control.

Parameters:
- NREGS, 32, number of architectural registers; x0 is never tracked.
- LOAD_LAT, 1, bubble cycles a dependent instruction needs after a load issues.
- LONG_LAT, 4, bubble cycles a dependent instruction needs after a long-latency op issues.
- CNT_W, $clog2(LONG_LAT+1), width of each per-register countdown.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  ID holds a valid instruction
- readReg1  in  5  ID source register 1
- readReg2  in  5  ID source register 2
- use1  in  1  ID instruction reads readReg1
- use2  in  1  ID instruction reads readReg2
- writeReg_ID  in  5  ID destination register
- regWrite_ID  in  1  ID instruction writes writeReg_ID
- memRead_ID  in  1  ID instruction is a load
- longOp_ID  in  1  ID instruction is a long-latency op
- flush  in  1  branch taken in EX; kills the ID instruction
- stallF  out  1  hold PC
- stallD  out  1  hold IF/ID
- flushE  out  1  insert bubble into ID/EX
- busyLong  out  1  a long-latency op is in flight

Behaviour:
- State:
  - cnt[1..NREGS-1], CNT_W bits each.
  - long_cnt, CNT_W bits: cycles until the long-latency unit is free.
- Reset: all cnt=0 and long_cnt=0. This gives stallF=stallD=flushE=busyLong=0 in the cycle after reset is sampled. Reset mid-operation discards all pending entries.
- RAW stall, combinational from state and current ID inputs:
  - raw = issue_valid & ((use1 & readReg1!=0 & cnt[readReg1]!=0) | (use2 & readReg2!=0 & cnt[readReg2]!=0)).
- WAW stall: waw = issue_valid & regWrite_ID & writeReg_ID!=0 & cnt[writeReg_ID]!=0.
- Structural stall: strc = issue_valid & longOp_ID & long_cnt!=0.
- Stall outputs:
  - stall = (raw|waw|strc) & ~flush.
  - stallF=stallD=flushE=stall.
  - busyLong = (long_cnt!=0).
- Issue: accept = issue_valid & ~stall & ~flush.
- Per-cycle update of each cnt entry:
  - If accept & regWrite_ID & writeReg_ID!=0 & entry==writeReg_ID, load LOAD_LAT when memRead_ID, LONG_LAT when longOp_ID, or 0 otherwise.
  - Otherwise decrement the entry if it is non-zero.
  - The issue load has priority over the decrement on the same entry.
- long_cnt update: load LONG_LAT on accept & longOp_ID; otherwise decrement if non-zero.
- memRead_ID and longOp_ID are never both set. If they are, longOp_ID wins.
- Latency:
  - A consumer in ID the cycle after a load issue sees exactly LOAD_LAT stall cycles.
  - For a long-latency op the consumer sees exactly LONG_LAT stall cycles.
  - Independent instructions see zero.
- flush:
  - Overrides stall, so the killed instruction never holds the front end.
  - Blocks issue, so no cnt entry is set.
  - Decrements of existing entries continue; they belong to older instructions.
- An x0 destination or source never stalls and never sets an entry.
- Counters saturate at 0; no wrap-around.

Optional Feature:
- Macro: HAZARD_STALL_STATS_EN.
- With the macro: adds output stall_cycles (32 bits).
  - Increments every cycle stall=1 and wraps at 2^32.
  - Reset to 0 by reset.
  - Also adds output raw_events (32 bits), incremented on each stall-cycle rising edge caused by raw.
- Without the macro: both ports and their counters are absent. Core behaviour is identical.

Decomposition:
- Shared package: regaddr_t (5-bit), NREGS, and the X0 constant. LOAD_LAT and LONG_LAT defaults also live there so the forwarding and MUL blocks agree.
- Sub-module: hazard_countdown holds one cnt entry with load, decrement and zero-detect. It is instantiated NREGS-1 times by generate, plus once for long_cnt.

Test Plan:
- Load-use: issue lw x5 (memRead_ID=1, writeReg_ID=5), then add x6,x5,x1 (use1, readReg1=5) → stall=1 for exactly 1 cycle, then accept; cnt[5]=0.
- Long op: mul x7 issued, then dependent sub reads x7 → 4 stall cycles. With a second mul issued immediately after the first → strc stall 4 cycles, busyLong=1 throughout.
- x0 immunity: lw x0, then add x1,x0,x0 → no stall; cnt unchanged.
- Flush priority: lw x5, then a dependent instruction in ID with flush=1 → stall=0, no entry set. cnt[5] still decrements to 0 next cycle.
- WAW plus simultaneous events:
  - Setup: mul x9, then lw x9 next cycle.
  - Required: waw stall until cnt[9]=0; lw is then accepted and cnt[9]=1.
  - Also: an accept on rd=9 in the same cycle cnt[9] decrements → cnt[9] loads the new value.
- Reset mid-stall: assert reset during the mul x7 dependency stall → next cycle all outputs 0. With HAZARD_STALL_STATS_EN defined, stall_cycles=0.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and latency defaults for the hazard stall unit, forwarding and MUL blocks.
package hazard_stall_unit_pkg;

  localparam int NREGS        = 32;
  localparam int LOAD_LAT_DEF = 1;
  localparam int LONG_LAT_DEF = 4;

  typedef logic [4:0] regaddr_t;

  localparam regaddr_t X0 = 5'd0;

  typedef enum logic [1:0] {
    LAT_NONE,
    LAT_LOAD,
    LAT_LONG
  } lat_class_t;

  // A long-latency op dominates when both class flags are (illegally) set.
  function automatic lat_class_t lat_class(input logic mem_read, input logic long_op);
    if (long_op) return LAT_LONG;
    if (mem_read) return LAT_LOAD;
    return LAT_NONE;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Decode-stage view of the hazard stall unit: ID instruction fields in, stall/bubble control out.
interface hazard_stall_unit_if;
  import hazard_stall_unit_pkg::*;

  logic     issue_valid;
  regaddr_t readReg1;
  regaddr_t readReg2;
  logic     use1;
  logic     use2;
  regaddr_t writeReg_ID;
  logic     regWrite_ID;
  logic     memRead_ID;
  logic     longOp_ID;
  logic     flush;
  logic     stallF;
  logic     stallD;
  logic     flushE;
  logic     busyLong;

  modport master (
    output issue_valid, readReg1, readReg2, use1, use2,
           writeReg_ID, regWrite_ID, memRead_ID, longOp_ID, flush,
    input  stallF, stallD, flushE, busyLong
  );

  modport slave (
    input  issue_valid, readReg1, readReg2, use1, use2,
           writeReg_ID, regWrite_ID, memRead_ID, longOp_ID, flush,
    output stallF, stallD, flushE, busyLong
  );

endinterface

// File: rtl/hazard_stall_unit_countdown.sv
// One saturating countdown entry: load wins over decrement, busy while non-zero.
module hazard_countdown #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         busy_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stalls the ID instruction until its operands are forwardable and the long-latency unit is free.
// Optional HAZARD_STALL_STATS_EN adds stall_cycles / raw_events counters.
module hazard_stall_unit #(
  parameter int NREGS    = hazard_stall_unit_pkg::NREGS,
  parameter int LOAD_LAT = hazard_stall_unit_pkg::LOAD_LAT_DEF,
  parameter int LONG_LAT = hazard_stall_unit_pkg::LONG_LAT_DEF,
  parameter int CNT_W    = $clog2(LONG_LAT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_unit_if.slave  id_if
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         raw_events
`endif
);
  import hazard_stall_unit_pkg::*;

  logic [NREGS-1:0] reg_busy;
  logic             long_busy;
  logic             raw;
  logic             waw;
  logic             strc;
  logic             stall;
  logic             accept;
  logic             wr_en;
  logic [CNT_W-1:0] wr_val;

  // x0 has no entry; a constant-zero busy bit keeps the lookups uniform.
  assign reg_busy[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg_cnt
      hazard_countdown #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wr_en && (id_if.writeReg_ID == regaddr_t'(gi))),
        .load_val_i (wr_val),
        .busy_o     (reg_busy[gi])
      );
    end
  endgenerate

  hazard_countdown #(.W(CNT_W)) u_long_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept && id_if.longOp_ID),
    .load_val_i (CNT_W'(LONG_LAT)),
    .busy_o     (long_busy)
  );

  assign raw = id_if.issue_valid &&
               ((id_if.use1 && (id_if.readReg1 != X0) && reg_busy[id_if.readReg1]) ||
                (id_if.use2 && (id_if.readReg2 != X0) && reg_busy[id_if.readReg2]));

  assign waw = id_if.issue_valid && id_if.regWrite_ID &&
               (id_if.writeReg_ID != X0) && reg_busy[id_if.writeReg_ID];

  assign strc = id_if.issue_valid && id_if.longOp_ID && long_busy;

  // A killed instruction must never hold the front end.
  assign stall  = (raw || waw || strc) && !id_if.flush;
  assign accept = id_if.issue_valid && !stall && !id_if.flush;
  assign wr_en  = accept && id_if.regWrite_ID && (id_if.writeReg_ID != X0);

  always_comb begin
    wr_val = '0;
    case (lat_class(id_if.memRead_ID, id_if.longOp_ID))
      LAT_LOAD: wr_val = CNT_W'(LOAD_LAT);
      LAT_LONG: wr_val = CNT_W'(LONG_LAT);
      default:  wr_val = '0;
    endcase
  end

  assign id_if.stallF   = stall;
  assign id_if.stallD   = stall;
  assign id_if.flushE   = stall;
  assign id_if.busyLong = long_busy;

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] raw_events_q;
  logic        stall_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      raw_events_q   <= '0;
      stall_prev_q   <= 1'b0;
    end else begin
      if (stall) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (stall && raw && !stall_prev_q) begin
        raw_events_q <= raw_events_q + 32'd1;
      end
      stall_prev_q <= stall;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign raw_events   = raw_events_q;
`endif

endmodule
